regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Round-robin arbiter for the single register-file write port. Shares it among NUM_REQ
//  writeback sources (scalar ALU, SIMD lanes, load unit, ...) using valid/ready handshakes.
//  Supports multi-beat bursts: a SIMD result writes consecutive registers back-to-back, and
//  the grant stays locked to that source until the burst ends. Drives write_enable,
//  write_addr and write_data of the register file from a registered output stage.
// PARAMETERS
//  NUM_REQ    4   number of writeback requesters (2..8)
//  ADDR_W     5   register address width
//  DATA_W     32  register data width
//  MAX_BURST  4   max beats per locked burst; reaching it forces release
//  DROP_R0    0   1: accepted beats to addr 0 are acked but not written
// PORTS
//  clk           in   1                clock, rising edge
//  reset         in   1                asynchronous, active-high
//  req_valid     in   NUM_REQ          per-source beat valid
//  req_last      in   NUM_REQ          per-source: this beat ends its burst
//  req_addr      in   NUM_REQ*ADDR_W   per-source dest addr, source i at [i*ADDR_W +: ADDR_W]
//  req_data      in   NUM_REQ*DATA_W   per-source write data, packed like req_addr
//  req_ready     out  NUM_REQ          per-source beat accepted this cycle (combinational)
//  rf_we         out  1                register-file write_enable
//  rf_waddr      out  ADDR_W           register-file write_addr
//  rf_wdata      out  DATA_W           register-file write_data
//  busy          out  1                1 while in LOCKED
//  burst_err     out  1                1-cycle pulse: burst cut at MAX_BURST with no last
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr_ptr=0, owner=0, beat_cnt=0.
//  - A beat is accepted when req_valid[i] && req_ready[i]. The port never stalls, so
//    ready == grant. At most one req_ready bit is high per cycle.
//  - IDLE: grant the first valid source at or after rr_ptr, scanning upward and wrapping
//    mod NUM_REQ. If no source is valid, there is no grant.
//    - Granted beat with last=1: stay IDLE; rr_ptr <= (g+1) mod NUM_REQ.
//    - Granted beat with last=0: go LOCKED; owner <= g; beat_cnt <= 1.
//  - LOCKED: only req_ready[owner] may be high (== req_valid[owner]). Other sources wait.
//    - Owner valid low: bubble cycle; nothing is written; stay LOCKED; no timeout.
//    - Accepted beat with last=1, or beat_cnt+1 == MAX_BURST: go IDLE;
//      rr_ptr <= (owner+1) mod NUM_REQ.
//    - Forced release (count reached, last=0): burst_err pulses in the cycle after that beat.
//  - Output stage: an accepted beat appears on rf_we/rf_waddr/rf_wdata exactly 1 cycle later.
//    rf_we=0 when no beat was accepted, or when DROP_R0=1 and addr==0.
//    rf_waddr/rf_wdata hold their last value while rf_we=0.
//  - Back-to-back beats give rf_we high on consecutive cycles (full throughput).
//  - req_last is ignored unless the beat is accepted. Address increment is the source's job.
//  - Reset mid-burst: immediate return to IDLE. Any pending output beat is discarded (rf_we=0).
//  - beat_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
// STRUCTURE
//  - Shared package (rf_pkg): RF_ADDR_W=5, RF_DATA_W=32, arbiter state enum {IDLE, LOCKED}.
//  - Sub-module rr_pick: combinational round-robin priority picker.
//    Inputs: valid vector, rr_ptr. Outputs: one-hot grant, grant index, any_valid.
//  - Top level: FSM, owner/beat_cnt/rr_ptr registers, output register stage.
// TESTING
//  1. Single shot: src2 valid, addr=7, data=0xDEADBEEF, last=1
//     -> ready[2] same cycle; next cycle rf_we=1, waddr=7, wdata=0xDEADBEEF.
//  2. Fairness: all 4 sources valid with last=1 every cycle, rr_ptr=0
//     -> grants 0,1,2,3,0 on consecutive cycles; rf_we high 5 cycles straight.
//  3. Burst lock: src1 sends addrs 8,9,10,11 (last on 11) while src0/src3 stay valid
//     -> only ready[1] for 4 cycles, busy=1; then src3 granted (rr_ptr=2 -> scan finds 3).
//  4. Bubble and cap: src0 bursts 5 beats with no last, with a valid gap after beat 2
//     -> no write in the gap cycle; forced release after beat 4; burst_err pulses once;
//     beat 5 is re-arbitrated.
//  5. DROP_R0=1: src1 writes addr 0, then addr 3
//     -> both acked; rf_we=0 for addr 0, rf_we=1 for addr 3.
//  6. Reset asserted mid-burst (after beat 2 of 4)
//     -> rf_we=0 and busy=0 immediately; after release, src0 wins first (rr_ptr=0).

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default port widths
// and the arbiter state encoding.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: one valid/last/addr/data lane per source plus the per-source
// ready returned by the arbiter.
interface regfile_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, req_last, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_last, req_addr, req_data, output req_ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid source at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_valid
);

  int idx;

  // Scan from the farthest offset down so the closest valid source to rr_ptr wins last.
  always_comb begin
    idx       = 0;
    grant_idx = '0;
    any_valid = |valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (valid[idx]) begin
        grant_idx = PTR_W'(idx);
      end
    end
    grant = any_valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NUM_REQ
// writeback sources, with burst locking and a registered write stage.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int MAX_BURST = 4,
  parameter bit DROP_R0   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                busy,
  output logic                burst_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic               burst_err_q, burst_err_d;

  logic [NUM_REQ-1:0] pick_grant, grant_vec;
  logic [PTR_W-1:0]   pick_idx, sel;
  logic               any_valid, accept, sel_last;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid     (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (any_valid)
  );

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign bus.req_ready = grant_vec;
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign busy          = (state_q == LOCKED);
  assign burst_err     = burst_err_q;

  // Grant is masked while reset is held so no source sees its beat taken.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = 1'b0;
    grant_vec   = '0;
    sel         = owner_q;

    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_vec = pick_grant;
            sel       = pick_idx;
          end
        end
        LOCKED: grant_vec[owner_q] = bus.req_valid[owner_q];
      endcase
    end

    accept   = |grant_vec;
    sel_last = bus.req_last[sel];
    sel_addr = bus.req_addr[int'(sel)*ADDR_W +: ADDR_W];
    sel_data = bus.req_data[int'(sel)*DATA_W +: DATA_W];

    if (accept) begin
      if (state_q == IDLE) begin
        if (sel_last) begin
          rr_ptr_d = wrap_inc(sel);
        end else begin
          state_d    = LOCKED;
          owner_d    = sel;
          beat_cnt_d = CNT_W'(1);
        end
      end else if (sel_last || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
        state_d     = IDLE;
        rr_ptr_d    = wrap_inc(owner_q);
        beat_cnt_d  = '0;
        burst_err_d = !sel_last;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    rf_we_d    = accept && !(DROP_R0 && sel_addr == '0);
    rf_waddr_d = rf_we_d ? sel_addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      burst_err_q <= burst_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued when a grant is
// expected and popped when the registered write port fires.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        burst_err;

  int  vectors;
  int  miscompares;
  wr_t sb_q[$];
  wr_t last_w;

  regfile_wb_arbiter_if #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) bus ();

  regfile_wb_arbiter #(
    .NUM_REQ   (4),
    .ADDR_W    (5),
    .DATA_W    (32),
    .MAX_BURST (4),
    .DROP_R0   (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .burst_err (burst_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setSrc(input int i, input logic v, input logic l,
                        input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i]       = v;
    bus.req_last[i]        = l;
    bus.req_addr[i*5 +: 5] = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic clearAll();
    for (int i = 0; i < 4; i++) setSrc(i, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  // Inputs are already driven at a falling edge; check ready, run one cycle, check the write port.
  task automatic applyStimulus(input logic [3:0] exp_ready, input string tag);
    bit  pend;
    wr_t w;
    pend = 1'b0;
    #1;
    checkOutput({tag, " ready"}, 32'(bus.req_ready), 32'(exp_ready));
    for (int k = 0; k < 4; k++) begin
      if (exp_ready[k] && bus.req_valid[k] && bus.req_addr[k*5 +: 5] != 5'd0) begin
        w.addr = bus.req_addr[k*5 +: 5];
        w.data = bus.req_data[k*32 +: 32];
        sb_q.push_back(w);
        pend = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " we"}, 32'(rf_we), 32'(pend));
    if (pend) begin
      w = sb_q.pop_front();
      checkOutput({tag, " waddr"}, 32'(rf_waddr), 32'(w.addr));
      checkOutput({tag, " wdata"}, rf_wdata, w.data);
      last_w = w;
    end else begin
      checkOutput({tag, " waddr hold"}, 32'(rf_waddr), 32'(last_w.addr));
      checkOutput({tag, " wdata hold"}, rf_wdata, last_w.data);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_w      = '0;
    reset       = 1'b1;
    clearAll();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset we", 32'(rf_we), 32'd0);
    checkOutput("reset waddr", 32'(rf_waddr), 32'd0);
    checkOutput("reset wdata", rf_wdata, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset burst_err", 32'(burst_err), 32'd0);
    checkOutput("reset ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single shot");
    setSrc(2, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
    applyStimulus(4'b0100, "single");
    clearAll();
    setSrc(3, 1'b1, 1'b1, 5'd5, 32'h0000_5555);
    applyStimulus(4'b1000, "single3");
    clearAll();

    $display("[TB] fairness");
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 4; i++) setSrc(i, 1'b1, 1'b1, 5'(i + 1), 32'h100 * s + 32'(i));
      applyStimulus(4'(1 << (s % 4)), "fair");
      checkOutput("fair busy", 32'(busy), 32'd0);
    end
    clearAll();

    $display("[TB] burst lock");
    setSrc(0, 1'b1, 1'b1, 5'd20, 32'hA000_0000);
    setSrc(3, 1'b1, 1'b1, 5'd23, 32'hA000_0003);
    for (int b = 0; b < 4; b++) begin
      setSrc(1, 1'b1, 1'(b == 3), 5'(8 + b), 32'hB000_0000 + 32'(b));
      applyStimulus(4'b0010, "lock");
      checkOutput("lock busy", 32'(busy), 32'(b < 3));
      checkOutput("lock burst_err", 32'(burst_err), 32'd0);
    end
    setSrc(1, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(4'b1000, "after lock");
    setSrc(3, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(4'b0001, "after lock src0");
    clearAll();

    $display("[TB] bubble and cap");
    setSrc(0, 1'b1, 1'b0, 5'd12, 32'hC000_0001);
    applyStimulus(4'b0001, "cap b1");
    setSrc(0, 1'b1, 1'b0, 5'd13, 32'hC000_0002);
    applyStimulus(4'b0001, "cap b2");
    setSrc(0, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(4'b0000, "cap gap");
    checkOutput("gap busy", 32'(busy), 32'd1);
    setSrc(0, 1'b1, 1'b0, 5'd14, 32'hC000_0003);
    applyStimulus(4'b0001, "cap b3");
    checkOutput("b3 burst_err", 32'(burst_err), 32'd0);
    setSrc(0, 1'b1, 1'b0, 5'd15, 32'hC000_0004);
    applyStimulus(4'b0001, "cap b4");
    checkOutput("b4 busy", 32'(busy), 32'd0);
    checkOutput("b4 burst_err", 32'(burst_err), 32'd1);
    setSrc(0, 1'b1, 1'b0, 5'd16, 32'hC000_0005);
    applyStimulus(4'b0001, "cap b5");
    checkOutput("b5 busy", 32'(busy), 32'd1);
    checkOutput("b5 burst_err", 32'(burst_err), 32'd0);
    setSrc(0, 1'b1, 1'b1, 5'd17, 32'hC000_0006);
    applyStimulus(4'b0001, "cap b6");
    checkOutput("b6 busy", 32'(busy), 32'd0);
    clearAll();

    $display("[TB] drop r0");
    setSrc(1, 1'b1, 1'b1, 5'd0, 32'hAAAA_AAAA);
    applyStimulus(4'b0010, "r0 drop");
    setSrc(1, 1'b1, 1'b1, 5'd3, 32'hBBBB_BBBB);
    applyStimulus(4'b0010, "r0 next");
    clearAll();

    $display("[TB] reset mid-burst");
    setSrc(0, 1'b1, 1'b0, 5'd24, 32'hD000_0001);
    applyStimulus(4'b0001, "rst b1");
    setSrc(0, 1'b1, 1'b0, 5'd25, 32'hD000_0002);
    applyStimulus(4'b0001, "rst b2");
    checkOutput("rst b2 busy", 32'(busy), 32'd1);
    setSrc(0, 1'b1, 1'b0, 5'd26, 32'hD000_0003);
    reset  = 1'b1;
    last_w = '0;
    #1;
    checkOutput("rst we", 32'(rf_we), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst held we", 32'(rf_we), 32'd0);
    reset = 1'b0;
    setSrc(0, 1'b1, 1'b1, 5'd26, 32'hD000_0003);
    setSrc(2, 1'b1, 1'b1, 5'd27, 32'hD000_0004);
    applyStimulus(4'b0001, "post rst");
    clearAll();
    applyStimulus(4'b0000, "idle");

    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
